// File: rtl/fifo_request_conditioner.sv
// Conditions two bouncy board-level request inputs into single-cycle FIFO read/write strobes,
// with debounce, optional auto-repeat and full/empty gating. Channel 0 is read, channel 1 write.
module fifo_request_conditioner #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_read,
    input  logic                  enable_write,
    input  logic [DATA_WIDTH-1:0] value_to_write,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  rd_pulse,
    output logic                  wr_pulse,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_blocked,
    output logic                  wr_blocked
);

    localparam int unsigned NumCh  = 2;
    localparam int unsigned DbW    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = (RptMax < 2) ? 1 : $clog2(RptMax + 1);
    localparam bit          RptEn  = (REPEAT_DELAY != 0);

    localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RptW-1:0] RptDelay  = RptW'(REPEAT_DELAY);
    localparam logic [RptW-1:0] RptPeriod = RptW'(REPEAT_PERIOD);

    logic [NumCh-1:0] raw_in;
    logic [NumCh-1:0] sync1_q, sync2_q;
    logic [NumCh-1:0] filt_q, filt_d;
    logic [NumCh-1:0] filt_prev_q;
    logic [DbW-1:0]   db_cnt_q  [NumCh];
    logic [DbW-1:0]   db_cnt_d  [NumCh];
    logic [RptW-1:0]  rpt_cnt_q [NumCh];
    logic [RptW-1:0]  rpt_cnt_d [NumCh];
    // 0: waiting out the initial delay, 1: running at the repeat period
    logic [NumCh-1:0] rpt_phase_q, rpt_phase_d;
    logic [NumCh-1:0] press;
    logic [NumCh-1:0] rpt_fire;
    logic [NumCh-1:0] req;

    logic                  rd_pulse_q, rd_pulse_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic                  rd_blocked_q, rd_blocked_d;
    logic                  wr_blocked_q, wr_blocked_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    assign raw_in = {enable_write, enable_read};

    always_comb begin
        filt_d      = filt_q;
        rpt_phase_d = rpt_phase_q;
        press       = '0;
        rpt_fire    = '0;
        req         = '0;
        for (int ch = 0; ch < NumCh; ch++) begin
            db_cnt_d[ch]  = db_cnt_q[ch];
            rpt_cnt_d[ch] = rpt_cnt_q[ch];

            // Any agreeing sample restarts the stability count
            if (sync2_q[ch] == filt_q[ch]) begin
                db_cnt_d[ch] = '0;
            end else if (db_cnt_q[ch] == DbLast) begin
                filt_d[ch]   = sync2_q[ch];
                db_cnt_d[ch] = '0;
            end else begin
                db_cnt_d[ch] = db_cnt_q[ch] + 1'b1;
            end

            press[ch] = filt_q[ch] & ~filt_prev_q[ch];

            if (!RptEn || !filt_q[ch]) begin
                rpt_cnt_d[ch]   = '0;
                rpt_phase_d[ch] = 1'b0;
            end else if (press[ch]) begin
                rpt_cnt_d[ch]   = RptW'(1);
                rpt_phase_d[ch] = 1'b0;
            end else if (rpt_cnt_q[ch] == (rpt_phase_q[ch] ? RptPeriod : RptDelay)) begin
                rpt_fire[ch]    = 1'b1;
                rpt_cnt_d[ch]   = RptW'(1);
                rpt_phase_d[ch] = 1'b1;
            end else begin
                rpt_cnt_d[ch] = rpt_cnt_q[ch] + 1'b1;
            end

            req[ch] = press[ch] | rpt_fire[ch];
        end
    end

    // Blocked requests are dropped; the repeat schedule above is unaffected
    always_comb begin
        rd_pulse_d   = req[0] & ~fifo_empty;
        rd_blocked_d = req[0] & fifo_empty;
        wr_pulse_d   = req[1] & ~fifo_full;
        wr_blocked_d = req[1] & fifo_full;
        wr_data_d    = '0;
        if (req[1] && !fifo_full) begin
            wr_data_d = value_to_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            filt_q       <= '0;
            filt_prev_q  <= '0;
            rpt_phase_q  <= '0;
            rd_pulse_q   <= 1'b0;
            wr_pulse_q   <= 1'b0;
            rd_blocked_q <= 1'b0;
            wr_blocked_q <= 1'b0;
            wr_data_q    <= '0;
            for (int ch = 0; ch < NumCh; ch++) begin
                db_cnt_q[ch]  <= '0;
                rpt_cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q      <= raw_in;
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            filt_prev_q  <= filt_q;
            rpt_phase_q  <= rpt_phase_d;
            rd_pulse_q   <= rd_pulse_d;
            wr_pulse_q   <= wr_pulse_d;
            rd_blocked_q <= rd_blocked_d;
            wr_blocked_q <= wr_blocked_d;
            wr_data_q    <= wr_data_d;
            for (int ch = 0; ch < NumCh; ch++) begin
                db_cnt_q[ch]  <= db_cnt_d[ch];
                rpt_cnt_q[ch] <= rpt_cnt_d[ch];
            end
        end
    end

    assign rd_pulse   = rd_pulse_q;
    assign wr_pulse   = wr_pulse_q;
    assign rd_blocked = rd_blocked_q;
    assign wr_blocked = wr_blocked_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_fifo_request_conditioner.sv
// Scoreboard bench: two conditioner instances (no repeat, and repeat 10/4) checked every cycle
// against expected strobe events queued when stimulus is applied.
module tb_fifo_request_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned DW = 32;

    typedef struct {
        int          cyc;
        logic        rd;
        logic        wr;
        logic        rb;
        logic        wb;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable_read = 1'b0;
    logic          enable_write = 1'b0;
    logic          enable_read_b = 1'b0;
    logic [DW-1:0] value_to_write = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_empty = 1'b0;

    logic          rd_a, wr_a, rb_a, wb_a;
    logic [DW-1:0] wdata_a;
    logic          rd_b, wr_b, rb_b, wb_b;
    logic [DW-1:0] wdata_b;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    fifo_request_conditioner #(
        .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
    ) dut_a (
        .clk(clk), .rst(rst),
        .enable_read(enable_read), .enable_write(enable_write),
        .value_to_write(value_to_write),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .rd_pulse(rd_a), .wr_pulse(wr_a), .wr_data(wdata_a),
        .rd_blocked(rb_a), .wr_blocked(wb_a)
    );

    fifo_request_conditioner #(
        .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .enable_read(enable_read_b), .enable_write(1'b0),
        .value_to_write(value_to_write),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .rd_pulse(rd_b), .wr_pulse(wr_b), .wr_data(wdata_b),
        .rd_blocked(rb_b), .wr_blocked(wb_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(int c, logic rd, logic wr, logic rb, logic wb, logic [31:0] d);
        exp_t e;
        e.cyc = c; e.rd = rd; e.wr = wr; e.rb = rb; e.wb = wb; e.data = d;
        return e;
    endfunction

    // Every cycle: outputs must match the queued event for this cycle, else be all zero
    always @(negedge clk) begin
        exp_t e;
        e = mk(cyc, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        while (qa.size() > 0 && qa[0].cyc < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL dut_a stale event for cycle %0d still queued at cycle %0d",
                     qa[0].cyc, cyc);
            void'(qa.pop_front());
        end
        if (qa.size() > 0 && qa[0].cyc == cyc) e = qa.pop_front();
        n_cmp++;
        if ({rd_a, wr_a, rb_a, wb_a, wdata_a} !== {e.rd, e.wr, e.rb, e.wb, e.data}) begin
            n_err++;
            $display("FAIL dut_a cycle %0d: got rd=%b wr=%b rb=%b wb=%b data=%h, want rd=%b wr=%b rb=%b wb=%b data=%h",
                     cyc, rd_a, wr_a, rb_a, wb_a, wdata_a, e.rd, e.wr, e.rb, e.wb, e.data);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = mk(cyc, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        while (qb.size() > 0 && qb[0].cyc < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL dut_b stale event for cycle %0d still queued at cycle %0d",
                     qb[0].cyc, cyc);
            void'(qb.pop_front());
        end
        if (qb.size() > 0 && qb[0].cyc == cyc) e = qb.pop_front();
        n_cmp++;
        if ({rd_b, wr_b, rb_b, wb_b, wdata_b} !== {e.rd, e.wr, e.rb, e.wb, e.data}) begin
            n_err++;
            $display("FAIL dut_b cycle %0d: got rd=%b wr=%b rb=%b wb=%b data=%h, want rd=%b wr=%b rb=%b wb=%b data=%h",
                     cyc, rd_b, wr_b, rb_b, wb_b, wdata_b, e.rd, e.wr, e.rb, e.wb, e.data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++;
        if ({rd_a, wr_a, rb_a, wb_a, wdata_a, rd_b, wr_b, rb_b, wb_b, wdata_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%b%b%b%b/%h b=%b%b%b%b/%h, want all zero",
                     rd_a, wr_a, rb_a, wb_a, wdata_a, rd_b, wr_b, rb_b, wb_b, wdata_b);
        end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_single_write();
        int c0;
        fifo_full = 1'b0;
        value_to_write = 32'hA5A5_0001;
        c0 = cyc;
        enable_write = 1'b1;
        qa.push_back(mk(c0 + D + 3, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001));
        tick(20);
        enable_write = 1'b0;
        tick(12);
        n_cmp++;
        if (qa.size() !== 0) begin
            n_err++;
            $display("FAIL single_write: got %0d pending events, want 0", qa.size());
        end
    endtask

    task automatic test_glitch_read();
        int c0;
        fifo_empty = 1'b0;
        for (int k = 0; k < 2; k++) begin
            enable_read = 1'b1;
            tick(3);
            enable_read = 1'b0;
            tick(3);
        end
        tick(4);
        c0 = cyc;
        enable_read = 1'b1;
        qa.push_back(mk(c0 + D + 3, 1'b1, 1'b0, 1'b0, 1'b0, '0));
        tick(10);
        enable_read = 1'b0;
        tick(12);
        n_cmp++;
        if (qa.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_read: got %0d pending events, want 0", qa.size());
        end
    endtask

    task automatic test_blocked();
        int c0;
        fifo_full = 1'b1;
        fifo_empty = 1'b0;
        value_to_write = 32'hDEAD_BEEF;
        c0 = cyc;
        enable_write = 1'b1;
        qa.push_back(mk(c0 + D + 3, 1'b0, 1'b0, 1'b0, 1'b1, '0));
        tick(12);
        enable_write = 1'b0;
        tick(12);
        fifo_full = 1'b0;
        fifo_empty = 1'b1;
        c0 = cyc;
        enable_read = 1'b1;
        qa.push_back(mk(c0 + D + 3, 1'b0, 1'b0, 1'b1, 1'b0, '0));
        tick(12);
        enable_read = 1'b0;
        tick(12);
        fifo_empty = 1'b0;
        n_cmp++;
        if (qa.size() !== 0) begin
            n_err++;
            $display("FAIL blocked: got %0d pending events, want 0", qa.size());
        end
    endtask

    task automatic test_both();
        int c0;
        value_to_write = 32'h1234_5678;
        c0 = cyc;
        enable_read = 1'b1;
        enable_write = 1'b1;
        qa.push_back(mk(c0 + D + 3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678));
        tick(15);
        enable_read = 1'b0;
        enable_write = 1'b0;
        tick(12);
        n_cmp++;
        if (qa.size() !== 0) begin
            n_err++;
            $display("FAIL both: got %0d pending events, want 0", qa.size());
        end
    endtask

    task automatic test_repeat();
        int c0;
        int offs[6] = '{0, 10, 14, 18, 22, 26};
        fifo_empty = 1'b0;
        c0 = cyc;
        enable_read_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            qb.push_back(mk(c0 + D + 3 + offs[k], 1'b1, 1'b0, 1'b0, 1'b0, '0));
        end
        // filt rises at c0+6 and falls at c0+36: held for 30 cycles
        tick(30);
        enable_read_b = 1'b0;
        tick(20);
        n_cmp++;
        if (qb.size() !== 0) begin
            n_err++;
            $display("FAIL repeat: got %0d pending events, want 0", qb.size());
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        value_to_write = 32'h0BAD_F00D;
        c0 = cyc;
        enable_write = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if ({rd_a, wr_a, rb_a, wb_a, wdata_a} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b%b%b%b/%h, want all zero",
                     rd_a, wr_a, rb_a, wb_a, wdata_a);
        end
        rst = 1'b0;
        // first edge out of reset is c0+7; pulse D+2 edges after that
        qa.push_back(mk(c0 + 7 + D + 2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D));
        tick(15);
        enable_write = 1'b0;
        tick(12);
        n_cmp++;
        if (qa.size() !== 0) begin
            n_err++;
            $display("FAIL reset_mid: got %0d pending events, want 0", qa.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_glitch_read();
        test_blocked();
        test_both();
        test_repeat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_request_conditioner.md
Name: fifo_request_conditioner

Overview:
- Turns two slow level inputs into clean single-cycle FIFO read and write strobes. The inputs are board buttons or switches for read and write.
- Per channel: 2-flop synchroniser, debounce filter, rising-edge detect, optional auto-repeat while held, gating against FIFO full/empty.
- Write data is captured into a register on each accepted write strobe.
- Sits between the board I/O and the FIFO core. Successor to the single-shot enable organiser, adding parametrised width, debounce, repeat and flow-control feedback.

Parameters:
- DATA_WIDTH, 32, width of value_to_write / wr_data.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change the filtered level (legal range >= 1).
- REPEAT_DELAY, 0, cycles from a request to the first auto-repeat while still held; 0 disables auto-repeat.
- REPEAT_PERIOD, 8, cycles between successive auto-repeats after the first (>= 1; ignored when REPEAT_DELAY = 0).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable_read  in  1  raw read request level (asynchronous, bouncy).
- enable_write  in  1  raw write request level (asynchronous, bouncy).
- value_to_write  in  DATA_WIDTH  write data, quasi-static; sampled unsynchronised.
- fifo_full  in  1  FIFO full flag (clk domain).
- fifo_empty  in  1  FIFO empty flag (clk domain).
- rd_pulse  out  1  one-cycle read strobe to the FIFO.
- wr_pulse  out  1  one-cycle write strobe to the FIFO.
- wr_data  out  DATA_WIDTH  captured data; valid only while wr_pulse = 1, otherwise 0.
- rd_blocked  out  1  one-cycle flag: a read request was dropped because fifo_empty was high.
- wr_blocked  out  1  one-cycle flag: a write request was dropped because fifo_full was high.

Behaviour:
- Reset: all outputs 0.
  - Synchroniser flops 0, filtered levels 0, debounce and repeat counters 0.
  - Reset applied mid-operation aborts any pending pulse or repeat.
  - An input held high through reset release is treated as a new press.
- Read and write channels are identical and fully independent. Both may pulse in the same cycle.
- Synchroniser: 2 flops per enable. raw_s is the second flop.
- Debounce:
  - The counter increments each edge while raw_s != filt.
  - It clears to 0 on any edge where raw_s == filt. A glitch shorter than D samples never changes filt.
  - When the count reaches DEBOUNCE_CYCLES (D), filt <= raw_s and the counter clears.
- Request event:
  - Occurs on the edge after filt rises (first press).
  - Also occurs on each auto-repeat expiry.
- Latency: input high and stable first sampled at edge 0 -> filt = 1 at edge D+1 -> pulse high for the cycle after edge D+2. With D = 4, the pulse is high for one cycle after edge 6.
- Auto-repeat (REPEAT_DELAY = R > 0):
  - While filt stays 1, a repeat request fires R cycles after the press request.
  - After that, a repeat request fires every REPEAT_PERIOD (P) cycles.
  - filt falling clears the repeat counter immediately; no further repeats.
- Gating, evaluated at the request edge using fifo_full / fifo_empty sampled at that same edge:
  - Write and fifo_full = 0: wr_pulse = 1 and wr_data <= value_to_write.
  - Write and fifo_full = 1: wr_blocked = 1; wr_pulse and wr_data stay 0.
  - Read and fifo_empty = 0: rd_pulse = 1.
  - Read and fifo_empty = 1: rd_blocked = 1.
  - Blocked requests are dropped, not queued. The repeat schedule continues regardless.
- Pulse width: every output pulse lasts exactly 1 cycle. wr_data returns to 0 the cycle after wr_pulse.
- Release: filt falls after D stable low samples. This produces no pulse. A new rising edge is needed for the next press event.

Test Plan:
- D=4, R=0: enable_write rises with value_to_write=32'hA5A5_0001, held 20 cycles, fifo_full=0 -> exactly one wr_pulse, high one cycle after edge 6; wr_data=32'hA5A5_0001 only in that cycle, else 0.
- D=4: enable_read toggles 1,0,1,0 with 3-cycle high/low segments, fifo_empty=0 -> no rd_pulse. Then held high 10 cycles -> one rd_pulse.
- fifo_full=1 on write press -> wr_blocked for 1 cycle, wr_pulse=0, wr_data=0. fifo_empty=1 on read press -> rd_blocked for 1 cycle.
- R=10, P=4: enable_read held 30 cycles after filt rises, fifo_empty=0 -> pulses at press+0, +10, +14, +18, +22, +26; none after release.
- Both enables rise on the same edge -> rd_pulse and wr_pulse in the same cycle.
- rst asserted 2 cycles before the expected pulse while the input is held -> no pulse at that time, all outputs 0. After release, one pulse D+2 edges later.
